// File: rtl/exa_crosb_pkg.sv
// Shared types and sizing helpers for the crossbar output-side arbitration.
//   arb_state_t : output arbiter FSM state (idle / packet locked)
//   log2()      : ceiling log2, never below 1, for port and counter sizing
package exa_crosb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/exa_rr_pick.sv
// Combinational round-robin picker.
//   req_vec : candidate requests
//   ptr     : index with highest priority; search goes upward and wraps
//   mask    : requests excluded from this decision
//   win_oh  : one-hot winner (zero when nothing eligible)
//   win_idx : binary index of the winner (zero when nothing eligible)
//   any_vld : at least one eligible request
module exa_rr_pick #(
  parameter int input_num = 16,
  parameter int sel_width = 4
) (
  input  logic [input_num-1:0] req_vec,
  input  logic [sel_width-1:0] ptr,
  input  logic [input_num-1:0] mask,
  output logic [input_num-1:0] win_oh,
  output logic [sel_width-1:0] win_idx,
  output logic                 any_vld
);

  logic [input_num-1:0] elig;

  assign elig = req_vec & ~mask;

  always_comb begin
    int idx;
    win_oh  = '0;
    win_idx = '0;
    any_vld = 1'b0;
    idx     = 0;
    for (int i = 0; i < input_num; i++) begin
      idx = int'(ptr) + i;
      if (idx >= input_num) idx = idx - input_num;
      if (!any_vld && elig[idx]) begin
        any_vld     = 1'b1;
        win_oh[idx] = 1'b1;
        win_idx     = sel_width'(idx);
      end
    end
  end

endmodule

// File: rtl/exa_crosb_out_arbiter.sv
// Packet-granular round-robin arbiter for one crossbar output port.
// A granted input owns the output until its LAST beat transfers; on that
// beat the next winner is loaded in the same cycle so packets stream
// back to back.
//   ACLK, ARESET : clock, async active-high reset
//   REQ_i        : per-input request for this output
//   VALID_i      : per-input beat valid
//   LAST_i       : per-input last beat
//   OUT_READY_i  : downstream can take a beat this cycle
//   GRANT_o      : registered one-hot grant (zero when idle)
//   SEL_o        : binary index of the granted input for the output mux
//   CTS_o        : per-input clear-to-send
//   BUSY_o       : a packet holds the output
//   ERR_o        : sticky overlong-packet flag
module exa_crosb_out_arbiter
  import exa_crosb_pkg::*;
#(
  parameter int input_num = 16,
  parameter int sel_width = log2(input_num),
  parameter int max_beats = 256,
  parameter int cnt_width = log2(max_beats) + 1
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic [input_num-1:0] REQ_i,
  input  logic [input_num-1:0] VALID_i,
  input  logic [input_num-1:0] LAST_i,
  input  logic                 OUT_READY_i,
  output logic [input_num-1:0] GRANT_o,
  output logic [sel_width-1:0] SEL_o,
  output logic [input_num-1:0] CTS_o,
  output logic                 BUSY_o,
  output logic                 ERR_o
);

  localparam logic [cnt_width-1:0] CNT_MAX  = '1;
  localparam logic [cnt_width-1:0] CNT_LIM  = cnt_width'(max_beats);
  localparam logic [sel_width-1:0] SEL_LAST = sel_width'(input_num - 1);

  arb_state_t           state, state_n;
  logic [sel_width-1:0] ptr, ptr_n, rel_ptr, pick_ptr, sel_n;
  logic [input_num-1:0] gnt_n, pick_mask, win_oh;
  logic [sel_width-1:0] win_idx;
  logic                 any_vld, busy_n, err_n, xfer, xlast;
  logic [cnt_width-1:0] cnt, cnt_n, cnt_inc;

  // Grant register is only non-zero while locked, but gate on state too so
  // CTS is unambiguously zero in IDLE.
  assign CTS_o   = (state == ARB_LOCKED) ? (GRANT_o & {input_num{OUT_READY_i}}) : '0;
  assign xfer    = |(VALID_i & CTS_o);
  assign xlast   = xfer && |(LAST_i & GRANT_o);
  assign rel_ptr = (SEL_o == SEL_LAST) ? '0 : SEL_o + sel_width'(1);
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + cnt_width'(1);

  // One picker serves both paths: from ptr in IDLE, and on release from the
  // post-release pointer with the finishing input masked out.
  assign pick_ptr  = (state == ARB_LOCKED) ? rel_ptr : ptr;
  assign pick_mask = (state == ARB_LOCKED) ? GRANT_o : '0;

  exa_rr_pick #(
    .input_num (input_num),
    .sel_width (sel_width)
  ) u_pick (
    .req_vec (REQ_i),
    .ptr     (pick_ptr),
    .mask    (pick_mask),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any_vld (any_vld)
  );

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = GRANT_o;
    sel_n   = SEL_o;
    busy_n  = BUSY_o;
    err_n   = ERR_o;
    cnt_n   = cnt;
    case (state)
      ARB_IDLE: begin
        if (any_vld) begin
          state_n = ARB_LOCKED;
          gnt_n   = win_oh;
          sel_n   = win_idx;
          busy_n  = 1'b1;
          cnt_n   = '0;
        end
      end
      ARB_LOCKED: begin
        if (xfer) begin
          cnt_n = cnt_inc;
          if (!xlast && cnt_inc == CNT_LIM) err_n = 1'b1;
        end
        if (xlast) begin
          ptr_n = rel_ptr;
          cnt_n = '0;
          if (any_vld) begin
            gnt_n = win_oh;
            sel_n = win_idx;
          end else begin
            state_n = ARB_IDLE;
            gnt_n   = '0;
            sel_n   = '0;
            busy_n  = 1'b0;
          end
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state   <= ARB_IDLE;
      ptr     <= '0;
      GRANT_o <= '0;
      SEL_o   <= '0;
      BUSY_o  <= 1'b0;
      ERR_o   <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      GRANT_o <= gnt_n;
      SEL_o   <= sel_n;
      BUSY_o  <= busy_n;
      ERR_o   <= err_n;
      cnt     <= cnt_n;
    end
  end

endmodule
